// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD tile sequencer: FSM states, panel command
// opcodes, panel/tile geometry defaults and the window-parameter byte picker.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET_CMD,
        S_CASET_PRM,
        S_PASET_CMD,
        S_PASET_PRM,
        S_RAMWR_CMD,
        S_PIXELS,
        S_ADVANCE
    } state_t;

    localparam logic [7:0]  LCD_CMD_CASET    = 8'h2A;
    localparam logic [7:0]  LCD_CMD_PASET    = 8'h2B;
    localparam logic [7:0]  LCD_CMD_RAMWR    = 8'h2C;

    localparam int          PANEL_W          = 240;
    localparam int          PANEL_H          = 320;
    localparam int          TILE_W_DEF       = 20;
    localparam int          TILE_H_DEF       = 20;
    localparam int          TILES_X_DEF      = PANEL_W / TILE_W_DEF;
    localparam int          TILES_Y_DEF      = PANEL_H / TILE_H_DEF;
    localparam logic [15:0] BORDER_COLOR_DEF = 16'h0000;

    // Window parameters go out as start MSB, start LSB, end MSB, end LSB.
    function automatic logic [7:0] window_byte(input logic [15:0] origin,
                                               input logic [15:0] span,
                                               input logic [1:0]  idx);
        logic [15:0] last_v;
        last_v = origin + span;
        case (idx)
            2'd0:    window_byte = origin[15:8];
            2'd1:    window_byte = origin[7:0];
            2'd2:    window_byte = last_v[15:8];
            default: window_byte = last_v[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lcd_tile_sequencer_if.sv
// Handshake/bus bundle around the tile sequencer: frame control, tile origin
// from the address generator, pixel source stream and LCD bus-write stream.
interface lcd_tile_sequencer_if;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic [15:0] col_start;
    logic [15:0] row_start;
    logic        addr_en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] lcd_word;
    logic        lcd_dc;
    logic        lcd_valid;
    logic        lcd_ready;

    modport master (
        input  start, col_start, row_start, pix_data, pix_valid, lcd_ready,
        output busy, frame_done, addr_en, pix_ready, lcd_word, lcd_dc, lcd_valid
    );

    modport slave (
        output start, col_start, row_start, pix_data, pix_valid, lcd_ready,
        input  busy, frame_done, addr_en, pix_ready, lcd_word, lcd_dc, lcd_valid
    );
endinterface

// File: rtl/lcd_tile_sequencer.sv
// Frame-fill controller: for every tile it programs the column/page window,
// opens a memory write, streams one tile of pixels to the LCD bus engine and
// then advances the external tile address generator.
// Optional build macro LCD_TILE_BORDER_EN: draws the first row and column of
// every tile in BORDER_COLOR instead of taking them from the pixel stream.
module lcd_tile_sequencer
    import lcd_pkg::*;
#(
    parameter int          TILE_W    = TILE_W_DEF,
    parameter int          TILE_H    = TILE_H_DEF,
    parameter int          TILES_X   = TILES_X_DEF,
    parameter int          TILES_Y   = TILES_Y_DEF,
    parameter logic [7:0]  CMD_CASET = LCD_CMD_CASET,
    parameter logic [7:0]  CMD_PASET = LCD_CMD_PASET,
    parameter logic [7:0]  CMD_RAMWR = LCD_CMD_RAMWR
`ifdef LCD_TILE_BORDER_EN
    ,
    parameter logic [15:0] BORDER_COLOR = BORDER_COLOR_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rstn,
    lcd_tile_sequencer_if.master bus
);

    localparam int NUM_TILES  = TILES_X * TILES_Y;
    localparam int TILE_CNT_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [TILE_CNT_W-1:0] TILE_LAST = TILE_CNT_W'(NUM_TILES - 1);
    localparam logic [15:0] COL_SPAN = 16'(TILE_W - 1);
    localparam logic [15:0] ROW_SPAN = 16'(TILE_H - 1);

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            prm_q;
    logic [TILE_CNT_W-1:0] tile_q;
    logic                  frame_done_q;
    logic                  pix_last;
    logic                  lcd_hs;
    logic                  valid_c;
    logic [15:0]           word_c;
    logic                  dc_c;
    logic                  pix_ready_c;
    logic                  addr_en_c;

`ifdef LCD_TILE_BORDER_EN
    localparam int X_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int Y_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(TILE_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(TILE_H - 1);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           on_border;

    assign on_border = (x_q == '0) || (y_q == '0);
    assign pix_last  = (x_q == X_LAST) && (y_q == Y_LAST);

    // Track the in-tile raster position of the next word leaving in PIXELS.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q <= '0;
            y_q <= '0;
        end else if (state_q == S_PIXELS && lcd_hs) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end
`else
    localparam int PIX_W = $clog2(TILE_W * TILE_H);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(TILE_W * TILE_H - 1);

    logic [PIX_W-1:0] pix_q;

    assign pix_last = (pix_q == PIX_LAST);

    // Count pixel words accepted by the bus engine within the current tile.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_q <= '0;
        end else if (state_q == S_PIXELS && lcd_hs) begin
            pix_q <= pix_last ? '0 : pix_q + 1'b1;
        end
    end
`endif

    assign lcd_hs = valid_c & bus.lcd_ready;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Parameter byte index, tile index and the registered end-of-frame pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prm_q        <= 2'd0;
            tile_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (state_q == S_ADVANCE) && (tile_q == TILE_LAST);
            if ((state_q == S_CASET_PRM || state_q == S_PASET_PRM) && bus.lcd_ready) begin
                prm_q <= prm_q + 2'd1;
            end
            if (state_q == S_ADVANCE) begin
                tile_q <= (tile_q == TILE_LAST) ? '0 : tile_q + 1'b1;
            end
        end
    end

    // Next-state decode and bus outputs for each step of the tile sequence.
    always_comb begin
        state_d     = state_q;
        valid_c     = 1'b0;
        word_c      = 16'h0000;
        dc_c        = 1'b0;
        pix_ready_c = 1'b0;
        addr_en_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_CASET_CMD;
            end
            S_CASET_CMD: begin
                valid_c = 1'b1;
                word_c  = {8'h00, CMD_CASET};
                if (bus.lcd_ready) state_d = S_CASET_PRM;
            end
            S_CASET_PRM: begin
                valid_c = 1'b1;
                dc_c    = 1'b1;
                word_c  = {8'h00, window_byte(bus.col_start, COL_SPAN, prm_q)};
                if (bus.lcd_ready && prm_q == 2'd3) state_d = S_PASET_CMD;
            end
            S_PASET_CMD: begin
                valid_c = 1'b1;
                word_c  = {8'h00, CMD_PASET};
                if (bus.lcd_ready) state_d = S_PASET_PRM;
            end
            S_PASET_PRM: begin
                valid_c = 1'b1;
                dc_c    = 1'b1;
                word_c  = {8'h00, window_byte(bus.row_start, ROW_SPAN, prm_q)};
                if (bus.lcd_ready && prm_q == 2'd3) state_d = S_RAMWR_CMD;
            end
            S_RAMWR_CMD: begin
                valid_c = 1'b1;
                word_c  = {8'h00, CMD_RAMWR};
                if (bus.lcd_ready) state_d = S_PIXELS;
            end
            S_PIXELS: begin
                dc_c = 1'b1;
`ifdef LCD_TILE_BORDER_EN
                if (on_border) begin
                    valid_c = 1'b1;
                    word_c  = BORDER_COLOR;
                end else begin
                    valid_c     = bus.pix_valid;
                    pix_ready_c = bus.lcd_ready;
                    word_c      = bus.pix_data;
                end
`else
                valid_c     = bus.pix_valid;
                pix_ready_c = bus.lcd_ready;
                word_c      = bus.pix_data;
`endif
                if (valid_c && bus.lcd_ready && pix_last) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                addr_en_c = 1'b1;
                state_d   = (tile_q == TILE_LAST) ? S_IDLE : S_CASET_CMD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = frame_done_q;
    assign bus.addr_en    = addr_en_c;
    assign bus.lcd_valid  = valid_c;
    assign bus.lcd_word   = word_c;
    assign bus.lcd_dc     = dc_c;
    assign bus.pix_ready  = pix_ready_c;

endmodule
